// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and frame-length helper for the TDM demux (TDM_DEMUX_PARITY_EN adds a parity slot)
package tdm_pkg;

    typedef enum logic {
        TDM_HUNT = 1'b0,
        TDM_RECV = 1'b1
    } tdm_state_t;

    localparam int TDM_N_CH_DEFAULT = 8;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int TDM_PARITY_SLOTS = 1;
`else
    localparam int TDM_PARITY_SLOTS = 0;
`endif

    // Slots per frame: one per channel plus the optional parity slot.
    function automatic int tdm_frame_len(input int n_ch);
        return n_ch + TDM_PARITY_SLOTS;
    endfunction

endpackage

// File: rtl/tdm_demux_1to8_if.sv
// rtl/tdm_demux_1to8_if.sv - serial slot input and recovered-word output bundle
interface tdm_demux_1to8_if
    import tdm_pkg::*;
#(
    parameter int N_CH  = TDM_N_CH_DEFAULT,
    parameter int SEL_W = $clog2(N_CH)
);
    logic             in_valid;
    logic             in_bit;
    logic             frame_sync;
    logic [N_CH-1:0]  out;
    logic             out_valid;
    logic [SEL_W-1:0] sel;
    logic             sync_err;
    logic             parity_err;

    modport slave (
        input  in_valid, in_bit, frame_sync,
        output out, out_valid, sel, sync_err, parity_err
    );

    modport master (
        output in_valid, in_bit, frame_sync,
        input  out, out_valid, sel, sync_err, parity_err
    );
endinterface

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - modulo-frame-length slot counter with clear, load-to-1 and increment
module tdm_slot_counter #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [CNT_W-1:0] slot,
    output logic             last
);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_LEN - 1);

    assign last = (slot == LAST_SLOT);

    // Slot index: clear wins over load, load wins over increment; wraps after the last slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= CNT_W'(1);
        end else if (inc) begin
            slot <= last ? '0 : slot + CNT_W'(1);
        end
    end
endmodule

// File: rtl/tdm_demux_1to8.sv
// rtl/tdm_demux_1to8.sv - 1:N TDM demultiplexer with frame-sync alignment (TDM_DEMUX_PARITY_EN enables parity slot)
module tdm_demux_1to8
    import tdm_pkg::*;
#(
    parameter int N_CH  = TDM_N_CH_DEFAULT,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    tdm_demux_1to8_if.slave    bus
);
    localparam int FRAME_LEN = tdm_frame_len(N_CH);
    localparam int CNT_W     = $clog2(FRAME_LEN);

    tdm_state_t       state;
    logic [N_CH-1:0]  shadow;
    logic [N_CH-1:0]  merged;
    logic [N_CH-1:0]  out_q;
    logic             out_valid_q;
    logic             sync_err_q;
    logic [CNT_W-1:0] slot;
    logic [SEL_W-1:0] slot_lo;
    logic             slot_last;
    logic             at_slot0;
    logic             cnt_clr;
    logic             cnt_load1;
    logic             cnt_inc;

    assign slot_lo  = slot[SEL_W-1:0];
    assign at_slot0 = (slot == '0);

    tdm_slot_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .slot  (slot),
        .last  (slot_last)
    );

    // Counter steering: any accepted sync beat restarts at slot 1, a missing sync at slot 0 returns to 0.
    always_comb begin
        cnt_clr   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        if (bus.in_valid) begin
            if (bus.frame_sync) begin
                cnt_load1 = 1'b1;
            end else if (state == TDM_RECV) begin
                if (at_slot0) begin
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
        end
    end

    // Shadow word with the current beat's bit dropped into its slot, used for the final data slot.
    always_comb begin
        merged          = shadow;
        merged[slot_lo] = bus.in_bit;
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic parity_err_q;
`endif

    // Framing FSM, shadow capture and registered outputs/pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= TDM_HUNT;
            shadow      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (bus.in_valid) begin
                case (state)
                    TDM_HUNT: begin
                        if (bus.frame_sync) begin
                            shadow[0] <= bus.in_bit;
                            state     <= TDM_RECV;
                        end
                    end
                    TDM_RECV: begin
                        if (bus.frame_sync) begin
                            // Sync anywhere but slot 0 abandons the partial frame and restarts here.
                            shadow[0] <= bus.in_bit;
                            if (!at_slot0) begin
                                sync_err_q <= 1'b1;
                            end
                        end else if (at_slot0) begin
                            sync_err_q <= 1'b1;
                            state      <= TDM_HUNT;
                        end else if (slot_last) begin
`ifdef TDM_DEMUX_PARITY_EN
                            out_q        <= shadow;
                            out_valid_q  <= 1'b1;
                            parity_err_q <= ((^shadow) != bus.in_bit);
`else
                            out_q       <= merged;
                            out_valid_q <= 1'b1;
`endif
                        end else begin
                            shadow[slot_lo] <= bus.in_bit;
                        end
                    end
                    default: state <= TDM_HUNT;
                endcase
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sync_err  = sync_err_q;

`ifdef TDM_DEMUX_PARITY_EN
    // The parity slot is the only index past N_CH-1, so it reads as the last data slot.
    assign bus.sel        = slot_last ? SEL_W'(N_CH - 1) : slot_lo;
    assign bus.parity_err = parity_err_q;
`else
    assign bus.sel        = slot_lo;
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// tb/tb_tdm_demux_1to8.sv - randomized self-checking bench for tdm_demux_1to8
module tb_tdm_demux_1to8;
    localparam int N = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN = N + PAR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdm_demux_1to8_if #(.N_CH(N)) bus ();

    tdm_demux_1to8 #(.N_CH(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: position within the frame (-1 = not aligned) and collected slot bits.
    int           pos = -1;
    bit           bits [0:N];
    logic [N-1:0] m_out = '0;
    bit           m_valid = 1'b0;
    bit           m_serr  = 1'b0;
    bit           m_perr  = 1'b0;

    function automatic int exp_sel();
        if (pos <= 0) return 0;
        if (pos > N - 1) return N - 1;
        return pos;
    endfunction

    task automatic model_reset();
        pos = -1; m_out = '0; m_valid = 1'b0; m_serr = 1'b0; m_perr = 1'b0;
    endtask

    task automatic drive_beat(input bit v, input bit b, input bit fs);
        bus.in_valid = v; bus.in_bit = b; bus.frame_sync = fs;
        @(posedge clk);
        cyc++;
        m_valid = 1'b0; m_serr = 1'b0; m_perr = 1'b0;
        if (v) begin
            if (fs) begin
                if (pos > 0) m_serr = 1'b1;
                bits[0] = b;
                pos = 1;
            end else if (pos == 0) begin
                m_serr = 1'b1;
                pos = -1;
            end else if (pos > 0) begin
                bits[pos] = b;
                pos++;
                if (pos == FLEN) begin
                    for (int k = 0; k < N; k++) m_out[k] = bits[k];
                    m_valid = 1'b1;
                    if (PAR != 0) m_perr = ((^m_out) != bits[N]);
                    pos = 0;
                end
            end
        end
        #1;
    endtask

    task automatic send_frame(input logic [N-1:0] d, input bit flip);
        bit b;
        for (int s = 0; s < FLEN; s++) begin
            b = (s < N) ? d[s] : ((^d) ^ flip);
            drive_beat(1'b1, b, s == 0);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.frame_sync = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", bus.out); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b want 0", bus.sync_err); end
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", bus.parity_err); end
        checks++; if (bus.sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", bus.sel); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_frame();
        send_frame(8'h4D, 1'b0);
        checks++; if (bus.out !== 8'h4D) begin errors++; $display("FAIL clean_out: got %h want 4d", bus.out); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clean_out_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL clean_sync_err: got %b want 0", bus.sync_err); end
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL clean_parity_err: got %b want 0", bus.parity_err); end
        drive_beat(1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clean_pulse_width: got %b want 0", bus.out_valid); end
        checks++; if (bus.out !== 8'h4D) begin errors++; $display("FAIL clean_hold: got %h want 4d", bus.out); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] d [2];
        int first = -1, second = -1, npulse = 0, nserr = 0;
        bit b;
        d[0] = 8'h4D; d[1] = 8'hA5;
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < FLEN; s++) begin
                b = (s < N) ? d[f][s] : (^d[f]);
                drive_beat(1'b1, b, s == 0);
                if (bus.out_valid === 1'b1) begin
                    npulse++;
                    if (f == 0) first = cyc; else second = cyc;
                end
                if (bus.sync_err === 1'b1) nserr++;
            end
        end
        checks++; if (npulse != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", npulse); end
        checks++; if (second - first != FLEN) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", second - first, FLEN); end
        checks++; if (bus.out !== 8'hA5) begin errors++; $display("FAIL b2b_out: got %h want a5", bus.out); end
        checks++; if (nserr != 0) begin errors++; $display("FAIL b2b_sync_err: got %0d want 0", nserr); end
    endtask

    task automatic test_gap();
        logic [N-1:0] d;
        bit b;
        d = 8'h4D;
        for (int s = 0; s < FLEN; s++) begin
            b = (s < N) ? d[s] : (^d);
            drive_beat(1'b1, b, s == 0);
            if (s == 3) begin
                for (int g = 0; g < 5; g++) begin
                    drive_beat(1'b0, 1'($urandom), 1'($urandom));
                    checks++; if (bus.sel !== 3'd4) begin errors++; $display("FAIL gap_sel: got %0d want 4", bus.sel); end
                    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL gap_valid: got %b want 0", bus.out_valid); end
                end
            end
        end
        checks++; if (bus.out !== 8'h4D) begin errors++; $display("FAIL gap_out: got %h want 4d", bus.out); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL gap_out_valid: got %b want 1", bus.out_valid); end
    endtask

    task automatic test_midframe_sync();
        logic [N-1:0] d1, d2;
        int nserr = 0, nvalid = 0;
        bit b;
        d1 = N'($urandom); d2 = N'($urandom);
        for (int s = 0; s < 5; s++) drive_beat(1'b1, d1[s], s == 0);
        for (int s = 0; s < FLEN; s++) begin
            b = (s < N) ? d2[s] : (^d2);
            drive_beat(1'b1, b, s == 0);
            if (s == 0) begin
                checks++; if (bus.sync_err !== 1'b1) begin errors++; $display("FAIL midsync_err: got %b want 1", bus.sync_err); end
                checks++; if (bus.out !== 8'h4D) begin errors++; $display("FAIL midsync_out_kept: got %h want 4d", bus.out); end
            end
            if (bus.sync_err === 1'b1) nserr++;
            if (bus.out_valid === 1'b1) nvalid++;
        end
        drive_beat(1'b0, 1'b0, 1'b0);
        checks++; if (nserr != 1) begin errors++; $display("FAIL midsync_err_count: got %0d want 1", nserr); end
        checks++; if (nvalid != 1) begin errors++; $display("FAIL midsync_valid_count: got %0d want 1", nvalid); end
        checks++; if (bus.out !== d2) begin errors++; $display("FAIL midsync_out: got %h want %h", bus.out, d2); end
    endtask

    task automatic test_unsynced_slot0();
        logic [N-1:0] d;
        int bad = 0;
        d = N'($urandom);
        send_frame(d, 1'b0);
        drive_beat(1'b1, 1'b1, 1'b0);
        checks++; if (bus.sync_err !== 1'b1) begin errors++; $display("FAIL unsync_err: got %b want 1", bus.sync_err); end
        checks++; if (bus.sel !== 3'd0) begin errors++; $display("FAIL unsync_sel: got %0d want 0", bus.sel); end
        for (int i = 0; i < 3; i++) begin
            drive_beat(1'b1, 1'($urandom), 1'b0);
            if (bus.sync_err !== 1'b0 || bus.out_valid !== 1'b0 || bus.sel !== 3'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL unsync_discard: got %0d bad beats want 0", bad); end
        checks++; if (bus.out !== d) begin errors++; $display("FAIL unsync_out_kept: got %h want %h", bus.out, d); end
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h4D, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL par_ok_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL par_ok_err: got %b want 0", bus.parity_err); end
        send_frame(8'h4D, 1'b1);
        checks++; if (bus.out !== 8'h4D) begin errors++; $display("FAIL par_bad_out: got %h want 4d", bus.out); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL par_bad_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_err: got %b want 1", bus.parity_err); end
        drive_beat(1'b0, 1'b0, 1'b0);
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL par_pulse_width: got %b want 0", bus.parity_err); end
    endtask
`endif

    task automatic test_async_reset();
        logic [N-1:0] d;
        d = 8'h4D;
        send_frame(8'hC3, 1'b0);
        for (int s = 0; s < 4; s++) drive_beat(1'b1, d[s], s == 0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL arst_out: got %h want 00", bus.out); end
        checks++; if (bus.sel !== 3'd0) begin errors++; $display("FAIL arst_sel: got %0d want 0", bus.sel); end
        checks++; if (bus.out_valid !== 1'b0 || bus.sync_err !== 1'b0 || bus.parity_err !== 1'b0) begin
            errors++; $display("FAIL arst_flags: got %b%b%b want 000", bus.out_valid, bus.sync_err, bus.parity_err);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'hA5, 1'b0);
        checks++; if (bus.out !== 8'hA5 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL arst_recover: got %h/%b want a5/1", bus.out, bus.out_valid);
        end
    endtask

    task automatic test_random();
        bit v, fs;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (pos <= 0) fs = ($urandom_range(0, 9) != 0);
            else fs = ($urandom_range(0, 24) == 0);
            drive_beat(v, 1'($urandom), fs);
            checks++; if (bus.out !== m_out) begin errors++; $display("FAIL rnd_out @%0d: got %h want %h", cyc, bus.out, m_out); end
            checks++; if (bus.out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, bus.out_valid, m_valid); end
            checks++; if (bus.sync_err !== m_serr) begin errors++; $display("FAIL rnd_sync_err @%0d: got %b want %b", cyc, bus.sync_err, m_serr); end
            checks++; if (bus.parity_err !== m_perr) begin errors++; $display("FAIL rnd_parity_err @%0d: got %b want %b", cyc, bus.parity_err, m_perr); end
            checks++; if (int'(bus.sel) != exp_sel()) begin errors++; $display("FAIL rnd_sel @%0d: got %0d want %0d", cyc, bus.sel, exp_sel()); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_back_to_back();
        test_gap();
        test_midframe_sync();
        test_unsynced_slot0();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end
endmodule
